// File: rtl/bp_pkg.sv
// Shared encodings and index/tag helpers for the branch predictor.
// Helpers take a zero-extended 64-bit PC; callers cast the result to IDX_W/TAG_W.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_t;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Word-aligned PC bits, optionally folded with global history (gshare).
    function automatic logic [31:0] bp_index(
        input logic [63:0]  pc,
        input logic [31:0]  ghr,
        input logic         gshare,
        input int unsigned  idx_w
    );
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return (32'(pc >> 2) ^ (gshare ? ghr : 32'd0)) & mask;
    endfunction

    function automatic logic [31:0] bp_tag(
        input logic [63:0]  pc,
        input int unsigned  lsb
    );
        return 32'(pc >> lsb);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating direction counter next-state; combinational, latency 0.
// Jumps force strongly-taken; no handshake.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    input  logic       force_strong,
    output logic [1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (force_strong) begin
            cnt_next = ST;
        end else if (taken) begin
            if (cnt != ST) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != SNT) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor_unit.sv
// Direct-mapped tagged BTB/BHT with bimodal or gshare indexing; lookup latency 0, update at next edge.
// No backpressure: updates arriving while sweeping, disabled or clearing are dropped.
module branch_predictor_unit
    import bp_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int GHR_W   = 6,
    parameter int MODE    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [DATA_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [DATA_W-1:0] upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [DATA_W-1:0] upd_target,
    input  logic              upd_mispredict,
    input  logic              clear,
    output logic              busy,
    output logic [31:0]       miss_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_LSB = IDX_W + 2;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [DATA_W-1:0] target_q [ENTRIES];
    logic [1:0]        cnt_q    [ENTRIES];

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  sweep_idx_q, sweep_idx_d;
    logic [GHR_W-1:0]  ghr_q, ghr_shift;
    logic [31:0]       miss_cnt_q;

    logic [IDX_W-1:0]  lk_idx, up_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    logic              up_hit, up_taken, apply;
    logic [1:0]        cnt_cur, cnt_next;

    logic              wr_en, wr_valid, wr_full;
    logic [IDX_W-1:0]  wr_idx;
    logic [1:0]        wr_cnt;

    assign lk_idx = IDX_W'(bp_index(64'(lookup_pc), 32'(ghr_q), MODE != 0, IDX_W));
    assign up_idx = IDX_W'(bp_index(64'(upd_pc), 32'(ghr_q), MODE != 0, IDX_W));
    assign lk_tag = TAG_W'(bp_tag(64'(lookup_pc), TAG_LSB));
    assign up_tag = TAG_W'(bp_tag(64'(upd_pc), TAG_LSB));

    assign busy        = (state_q == SWEEP);
    assign pred_hit    = !busy && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = pred_hit && cnt_q[lk_idx][1];
    assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + DATA_W'(4);
    assign miss_cnt    = miss_cnt_q;

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        case (state_q)
            SWEEP: begin
                if (clear) begin
                    sweep_idx_d = '0;
                end else if (sweep_idx_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = RUN;
                end else begin
                    sweep_idx_d = sweep_idx_q + 1'b1;
                end
            end
            RUN: begin
                if (clear) begin
                    state_d     = SWEEP;
                    sweep_idx_d = '0;
                end
            end
            default: state_d = SWEEP;
        endcase
    end

    // Jumps count as taken; a miss starts from WNT so a taken branch lands on WT.
    assign apply    = (state_q == RUN) && en && upd_valid && !clear;
    assign up_taken = upd_is_jump || upd_taken;
    assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign cnt_cur  = up_hit ? cnt_q[up_idx] : WNT;

    bp_sat_counter u_cnt (
        .cnt          (cnt_cur),
        .taken        (up_taken),
        .force_strong (upd_is_jump),
        .cnt_next     (cnt_next)
    );

    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = up_idx;
        wr_valid = 1'b1;
        wr_cnt   = cnt_next;
        wr_full  = up_taken;
        if (state_q == SWEEP) begin
            wr_en    = 1'b1;
            wr_idx   = sweep_idx_q;
            wr_valid = 1'b0;
            wr_cnt   = WNT;
            wr_full  = 1'b0;
        end else if (apply && (up_hit || up_taken)) begin
            wr_en = 1'b1;
        end
    end

    // Storage is deliberately unreset; the sweep establishes a clean table.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            valid_q[wr_idx] <= wr_valid;
            cnt_q[wr_idx]   <= wr_cnt;
            if (wr_full) begin
                tag_q[wr_idx]    <= up_tag;
                target_q[wr_idx] <= upd_target;
            end
        end
    end

    if (GHR_W == 1) begin : g_ghr1
        assign ghr_shift = upd_taken;
    end else begin : g_ghrn
        assign ghr_shift = {ghr_q[GHR_W-2:0], upd_taken};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SWEEP;
            sweep_idx_q <= '0;
            ghr_q       <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            if (apply && !upd_is_jump) ghr_q <= ghr_shift;
            if (apply && upd_mispredict && (miss_cnt_q != 32'hFFFF_FFFF))
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Drives a bimodal and a gshare instance with the same directed stream; checks both against a table model.
module tb_branch_predictor_unit;
    localparam int E = 64;

    logic        clk = 1'b0;
    logic        rst, en, upd_valid, upd_is_jump, upd_taken, upd_mispredict, clear;
    logic [63:0] lookup_pc, upd_pc, upd_target;
    logic        hit0, taken0, busy0, hit1, taken1, busy1;
    logic [63:0] tgt0, tgt1;
    logic [31:0] miss0, miss1;

    int n_chk = 0, n_err = 0;
    bit chk_en = 1'b0;

    // model state
    bit          m_valid [2][E];
    int          m_tag   [2][E];
    logic [63:0] m_tgt   [2][E];
    int          m_cnt   [2][E];
    int          m_ghr   [2];
    logic [31:0] m_miss  [2];
    int          busy_left = E;

    always #10 clk = ~clk;

    branch_predictor_unit #(.MODE(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .lookup_pc(lookup_pc),
        .pred_hit(hit0), .pred_taken(taken0), .pred_target(tgt0),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .clear(clear), .busy(busy0), .miss_cnt(miss0));

    branch_predictor_unit #(.MODE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .lookup_pc(lookup_pc),
        .pred_hit(hit1), .pred_taken(taken1), .pred_target(tgt1),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .clear(clear), .busy(busy1), .miss_cnt(miss1));

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int midx(input int m, input logic [63:0] pc);
        int i;
        i = int'((pc >> 2) % E);
        if (m == 1) i = i ^ m_ghr[m];
        return i;
    endfunction

    function automatic int mtag(input logic [63:0] pc);
        return int'((pc >> 8) & 64'hFF);
    endfunction

    task automatic model_apply(input int m);
        int  i, t, c;
        bit  tk;
        tk = upd_is_jump || upd_taken;
        i  = midx(m, upd_pc);
        t  = mtag(upd_pc);
        if (m_valid[m][i] && m_tag[m][i] == t) begin
            c = m_cnt[m][i];
            if (upd_is_jump) c = 3;
            else if (tk)     c = (c == 3) ? 3 : c + 1;
            else             c = (c == 0) ? 0 : c - 1;
            m_cnt[m][i] = c;
            if (tk) m_tgt[m][i] = upd_target;
        end else if (tk) begin
            m_valid[m][i] = 1'b1;
            m_tag[m][i]   = t;
            m_tgt[m][i]   = upd_target;
            m_cnt[m][i]   = upd_is_jump ? 3 : 2;
        end
        if (!upd_is_jump) m_ghr[m] = ((m_ghr[m] << 1) | int'(upd_taken)) & 63;
        if (upd_mispredict && m_miss[m] != 32'hFFFF_FFFF) m_miss[m] = m_miss[m] + 1;
    endtask

    task automatic invalidate_all();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < E; i++) m_valid[m][i] = 1'b0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            busy_left = E;
            invalidate_all();
            for (int m = 0; m < 2; m++) begin
                m_ghr[m]  = 0;
                m_miss[m] = 32'd0;
            end
        end else if (busy_left > 0) begin
            if (clear) busy_left = E;
            else       busy_left--;
        end else if (clear) begin
            busy_left = E;
            invalidate_all();
        end else if (en && upd_valid) begin
            for (int m = 0; m < 2; m++) model_apply(m);
        end
    end

    task automatic check_dut(input int m, input logic b, input logic h, input logic tk,
                             input logic [63:0] tg, input logic [31:0] mc);
        int i;
        bit eh, et;
        logic [63:0] etg;
        i   = midx(m, lookup_pc);
        eh  = (busy_left == 0) && m_valid[m][i] && (m_tag[m][i] == mtag(lookup_pc));
        et  = eh && (m_cnt[m][i] >= 2);
        etg = et ? m_tgt[m][i] : lookup_pc + 64'd4;
        cmp($sformatf("model_busy%0d", m), 64'(b), 64'(busy_left > 0));
        cmp($sformatf("model_hit%0d", m), 64'(h), 64'(eh));
        cmp($sformatf("model_taken%0d", m), 64'(tk), 64'(et));
        cmp($sformatf("model_target%0d", m), tg, etg);
        cmp($sformatf("model_miss%0d", m), 64'(mc), 64'(m_miss[m]));
    endtask

    always begin
        @(negedge clk);
        #3;
        if (chk_en) begin
            check_dut(0, busy0, hit0, taken0, tgt0, miss0);
            check_dut(1, busy1, hit1, taken1, tgt1, miss1);
        end
    end

    task automatic upd(input logic [63:0] pc, input logic jmp, input logic tk,
                       input logic [63:0] tgt, input logic mis);
        upd_valid = 1'b1; upd_pc = pc; upd_is_jump = jmp; upd_taken = tk;
        upd_target = tgt; upd_mispredict = mis;
        @(negedge clk);
        upd_valid = 1'b0; upd_is_jump = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    endtask

    task automatic chk_look(input string nm, input int m, input logic [63:0] pc,
                            input logic eh, input logic et, input logic [63:0] etg);
        lookup_pc = pc;
        #3;
        if (m == 0) begin
            cmp({nm, "_hit"}, 64'(hit0), 64'(eh));
            cmp({nm, "_taken"}, 64'(taken0), 64'(et));
            cmp({nm, "_target"}, tgt0, etg);
        end else begin
            cmp({nm, "_hit"}, 64'(hit1), 64'(eh));
            cmp({nm, "_taken"}, 64'(taken1), 64'(et));
            cmp({nm, "_target"}, tgt1, etg);
        end
        @(negedge clk);
    endtask

    // entered 3 time units after a falling edge; leaves aligned on a falling edge
    task automatic count_busy(input string nm);
        int n;
        n = 0;
        while (busy0 && n < 200) begin
            n++;
            @(negedge clk);
            #3;
        end
        cmp(nm, 64'(n), 64'(E));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; clear = 1'b0; upd_valid = 1'b0; upd_is_jump = 1'b0;
        upd_taken = 1'b0; upd_mispredict = 1'b0; upd_pc = '0; upd_target = '0;
        lookup_pc = 64'h100;
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        #3;
        cmp("rst_busy", 64'(busy0), 64'd1);
        cmp("rst_hit", 64'(hit0), 64'd0);
        cmp("rst_target", tgt0, 64'h104);
        cmp("rst_miss", 64'(miss0), 64'd0);
        count_busy("init_busy_cycles");

        en = 1'b0;
        upd(64'h500, 1'b0, 1'b1, 64'h10, 1'b1);
        en = 1'b1;
        chk_look("en_drop", 0, 64'h500, 1'b0, 1'b0, 64'h504);

        upd(64'h200, 1'b0, 1'b1, 64'h180, 1'b1);
        upd(64'h200, 1'b0, 1'b1, 64'h180, 1'b1);
        chk_look("br_taken", 0, 64'h200, 1'b1, 1'b1, 64'h180);
        for (int k = 0; k < 3; k++) upd(64'h200, 1'b0, 1'b0, 64'h0, 1'b0);
        chk_look("br_not_taken", 0, 64'h200, 1'b1, 1'b0, 64'h204);

        upd(64'h200 + E * 4, 1'b0, 1'b1, 64'h900, 1'b1);
        chk_look("alias_old", 0, 64'h200, 1'b0, 1'b0, 64'h204);
        chk_look("alias_new", 0, 64'h300, 1'b1, 1'b1, 64'h900);

        // jump written this edge is invisible to the same-cycle lookup
        lookup_pc = 64'h40;
        upd_valid = 1'b1; upd_pc = 64'h40; upd_is_jump = 1'b1; upd_taken = 1'b0;
        upd_target = 64'h1000; upd_mispredict = 1'b0;
        #3;
        cmp("jump_same_cycle_hit", 64'(hit0), 64'd0);
        cmp("jump_same_cycle_target", tgt0, 64'h44);
        @(negedge clk);
        upd_valid = 1'b0; upd_is_jump = 1'b0;
        chk_look("jump_next", 0, 64'h40, 1'b1, 1'b1, 64'h1000);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        count_busy("rst2_busy_cycles");
        upd(64'h10, 1'b0, 1'b1, 64'h500, 1'b0);
        upd(64'h20, 1'b0, 1'b0, 64'h0, 1'b0);
        upd(64'h30, 1'b0, 1'b1, 64'h600, 1'b0);
        chk_look("gshare_xor_entry", 1, 64'h2C, 1'b1, 1'b1, 64'h600);
        chk_look("gshare_plain_entry", 1, 64'h30, 1'b0, 1'b0, 64'h34);
        chk_look("bimodal_plain_entry", 0, 64'h30, 1'b1, 1'b1, 64'h600);

        clear = 1'b1;
        upd(64'h400, 1'b0, 1'b1, 64'h700, 1'b1);
        clear = 1'b0;
        #3;
        count_busy("clear_busy_cycles");
        chk_look("clear_dropped_upd", 0, 64'h400, 1'b0, 1'b0, 64'h404);
        chk_look("clear_invalidated", 0, 64'h30, 1'b0, 1'b0, 64'h34);

        dut0.miss_cnt_q = 32'hFFFF_FFFD;
        m_miss[0] = 32'hFFFF_FFFD;
        upd(64'h600, 1'b0, 1'b1, 64'h800, 1'b1);
        #3;
        cmp("miss_near_sat", 64'(miss0), 64'hFFFF_FFFE);
        @(negedge clk);
        upd(64'h600, 1'b0, 1'b1, 64'h800, 1'b1);
        upd(64'h600, 1'b0, 1'b1, 64'h800, 1'b1);
        #3;
        cmp("miss_saturated", 64'(miss0), 64'hFFFF_FFFF);
        cmp("miss_gshare_count", 64'(miss1), 64'd3);
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
